vram_rd_arb: RTL and testbench

Two-requester AXI read-channel arbiter that shares the single display-side AXI master read port between the display VRAM controller (requester 0) and a second VRAM reader (requester 1, e.g. drawing/capture engine). It sits between the requesters' AR/R channels and the M_AXI_AR*/M_AXI_R* ports of the display top, grants one burst at a time, tags the burst with ARID, and steers read data back to the owner. All logic runs on ACLK.

---
 rtl/vram_rd_arb_pkg.sv | 21 ++
 rtl/vram_rd_arb_if.sv | 66 ++++++
 rtl/vram_rd_arb_beatchk.sv | 50 +++++
 rtl/vram_rd_arb.sv | 140 ++++++++++++++
 tb/tb_vram_rd_arb.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_rd_arb_pkg.sv
// Shared types and constants for the two-requester VRAM read arbiter.
package vram_rd_arb_pkg;

    localparam int unsigned LEN_W = 8;

    localparam logic [2:0] ARSIZE_8B    = 3'b011;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Registered burst tag: owner index plus burst length minus one.
    typedef struct packed {
        logic             id;
        logic [LEN_W-1:0] len;
    } ar_ctl_t;

endpackage

// File: rtl/vram_rd_arb_if.sv
// AR/R signal bundle between the two requesters, the arbiter and the AXI read port.
// master = arbiter view, slave = requesters plus AXI slave view.
interface vram_rd_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0] S0_ARADDR;
    logic [7:0]        S0_ARLEN;
    logic              S0_ARVALID;
    logic              S0_ARREADY;
    logic              S0_RVALID;
    logic              S0_RREADY;

    logic [ADDR_W-1:0] S1_ARADDR;
    logic [7:0]        S1_ARLEN;
    logic              S1_ARVALID;
    logic              S1_ARREADY;
    logic              S1_RVALID;
    logic              S1_RREADY;

    logic [DATA_W-1:0] S_RDATA;
    logic              S_RLAST;

    logic              M_AXI_ARID;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;

    logic              M_AXI_RID;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic              M_AXI_RLAST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    logic              ARB_ERR;

    modport master (
        input  S0_ARADDR, S0_ARLEN, S0_ARVALID, S0_RREADY,
        input  S1_ARADDR, S1_ARLEN, S1_ARVALID, S1_RREADY,
        output S0_ARREADY, S0_RVALID, S1_ARREADY, S1_RVALID,
        output S_RDATA, S_RLAST,
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
        output M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RID, M_AXI_RDATA, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY,
        output ARB_ERR
    );

    modport slave (
        output S0_ARADDR, S0_ARLEN, S0_ARVALID, S0_RREADY,
        output S1_ARADDR, S1_ARLEN, S1_ARVALID, S1_RREADY,
        input  S0_ARREADY, S0_RVALID, S1_ARREADY, S1_RVALID,
        input  S_RDATA, S_RLAST,
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
        input  M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RID, M_AXI_RDATA, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  ARB_ERR
    );

endinterface

// File: rtl/vram_rd_arb_beatchk.sv
// Per-burst beat counter and RLAST/RID consistency checker; raises a sticky error flag.
module vram_rd_arb_beatchk
    import vram_rd_arb_pkg::*;
(
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start,
    input  logic             beat,
    input  logic             rlast,
    input  logic             rid,
    input  logic             arid,
    input  logic [LEN_W-1:0] arlen,
    output logic             ARB_ERR
);

    logic [LEN_W-1:0] cnt_q;
    logic             at_end_c;
    logic             err_c;

    assign at_end_c = (cnt_q == arlen);

    // RLAST must coincide exactly with the final beat, and RID must match the owner.
    always_comb begin
        err_c = 1'b0;
        if (beat) begin
            if (rlast != at_end_c) err_c = 1'b1;
            if (rid != arid)       err_c = 1'b1;
        end
    end

    // Counter saturates at ARLEN so an overlong burst keeps flagging instead of wrapping.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (beat && !at_end_c) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ARB_ERR <= 1'b0;
        end else if (err_c) begin
            ARB_ERR <= 1'b1;
        end
    end

endmodule

// File: rtl/vram_rd_arb.sv
// Two-requester AXI read arbiter: one burst at a time, ARID-tagged, R data steered to the owner.
// Define VRAM_RD_ARB_S0_PRIO_EN for fixed S0 priority; otherwise round-robin.
module vram_rd_arb
    import vram_rd_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    vram_rd_arb_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    logic              req_any_c;
    logic              winner_c;
    logic              accept_c;
    logic              r_hs_c;
    logic [ADDR_W-1:0] araddr_q;
    ar_ctl_t           ar_q;
    logic              arb_err;

    logic              s0_arready_c;
    logic              s1_arready_c;
    logic              s0_rvalid_c;
    logic              s1_rvalid_c;
    logic              m_arvalid_c;
    logic              m_rready_c;

    assign req_any_c = bus.S0_ARVALID | bus.S1_ARVALID;
    assign accept_c  = (state_q == IDLE) & req_any_c;
    assign r_hs_c    = (state_q == DATA) & bus.M_AXI_RVALID & m_rready_c;

`ifndef VRAM_RD_ARB_S0_PRIO_EN
    logic last_grant_q;

    // Resets to 1 so that S0 wins the first contest.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_grant_q <= 1'b1;
        end else if (accept_c) begin
            last_grant_q <= winner_c;
        end
    end
`endif

    // Winner selection among the current requests.
    always_comb begin
        winner_c = 1'b0;
`ifdef VRAM_RD_ARB_S0_PRIO_EN
        if (bus.S1_ARVALID && !bus.S0_ARVALID) winner_c = 1'b1;
`else
        if (bus.S0_ARVALID && bus.S1_ARVALID) winner_c = ~last_grant_q;
        else if (bus.S1_ARVALID)              winner_c = 1'b1;
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_any_c)                     state_d = ADDR;
            ADDR:    if (bus.M_AXI_ARREADY)             state_d = DATA;
            DATA:    if (r_hs_c && bus.M_AXI_RLAST)     state_d = IDLE;
            default:                                    state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; R path is a pure mux onto the owner.
    always_comb begin
        s0_arready_c = 1'b0;
        s1_arready_c = 1'b0;
        s0_rvalid_c  = 1'b0;
        s1_rvalid_c  = 1'b0;
        m_arvalid_c  = 1'b0;
        m_rready_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                s0_arready_c = req_any_c & ~winner_c;
                s1_arready_c = req_any_c &  winner_c;
            end
            ADDR: begin
                m_arvalid_c = 1'b1;
            end
            DATA: begin
                m_rready_c  = ar_q.id ? bus.S1_RREADY : bus.S0_RREADY;
                s0_rvalid_c = ~ar_q.id & bus.M_AXI_RVALID;
                s1_rvalid_c =  ar_q.id & bus.M_AXI_RVALID;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            araddr_q <= '0;
            ar_q     <= '0;
        end else if (accept_c) begin
            araddr_q <= winner_c ? bus.S1_ARADDR : bus.S0_ARADDR;
            ar_q.id  <= winner_c;
            ar_q.len <= winner_c ? bus.S1_ARLEN : bus.S0_ARLEN;
        end
    end

    vram_rd_arb_beatchk u_beatchk (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (accept_c),
        .beat    (r_hs_c),
        .rlast   (bus.M_AXI_RLAST),
        .rid     (bus.M_AXI_RID),
        .arid    (ar_q.id),
        .arlen   (ar_q.len),
        .ARB_ERR (arb_err)
    );

    assign bus.S0_ARREADY    = s0_arready_c;
    assign bus.S1_ARREADY    = s1_arready_c;
    assign bus.S0_RVALID     = s0_rvalid_c;
    assign bus.S1_RVALID     = s1_rvalid_c;
    assign bus.S_RDATA       = DATA_W'(bus.M_AXI_RDATA);
    assign bus.S_RLAST       = bus.M_AXI_RLAST;
    assign bus.M_AXI_ARID    = ar_q.id;
    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARLEN   = ar_q.len;
    assign bus.M_AXI_ARSIZE  = ARSIZE_8B;
    assign bus.M_AXI_ARBURST = ARBURST_INCR;
    assign bus.M_AXI_ARVALID = m_arvalid_c;
    assign bus.M_AXI_RREADY  = m_rready_c;
    assign bus.ARB_ERR       = arb_err;

endmodule

// File: tb/tb_vram_rd_arb.sv
// Directed bench for vram_rd_arb: arbitration order, AR hold, R steering, error flag, async reset.
module tb_vram_rd_arb;

    logic ACLK;
    logic ARESETN;
    int   ntests;
    int   nfail;

    vram_rd_arb_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    vram_rd_arb #(.ADDR_W(32), .DATA_W(64)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(negedge ACLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present requests at a negedge in IDLE, check the same-cycle grant, step past the accept edge.
    task automatic grant(input logic s0v, input logic s1v, input logic w, input logic drop);
        bus.S0_ARVALID = s0v;
        bus.S1_ARVALID = s1v;
        #1;
        chk("arb_grant", 64'({bus.S1_ARREADY, bus.S0_ARREADY}), w ? 64'h2 : 64'h1);
        cyc();
        if (drop) begin
            bus.S0_ARVALID = 1'b0;
            bus.S1_ARVALID = 1'b0;
        end
    endtask

    // AXI slave address phase: hold ARREADY low for 'delay' cycles, checking stability.
    task automatic do_addr(input logic w, input logic [31:0] addr, input logic [7:0] len,
                           input int delay);
        int hi;
        hi = 0;
        for (int d = 0; d <= delay; d++) begin
            #1;
            if (bus.M_AXI_ARVALID === 1'b1) hi++;
            chk("ar_id",   64'(bus.M_AXI_ARID),   64'(w));
            chk("ar_addr", 64'(bus.M_AXI_ARADDR), 64'(addr));
            chk("ar_len",  64'(bus.M_AXI_ARLEN),  64'(len));
            chk("ar_req_wait", 64'({bus.S1_ARREADY, bus.S0_ARREADY}), 64'h0);
            if (d == 0) begin
                chk("ar_size",  64'(bus.M_AXI_ARSIZE),  64'h3);
                chk("ar_burst", 64'(bus.M_AXI_ARBURST), 64'h1);
            end
            if (d == delay) bus.M_AXI_ARREADY = 1'b1;
            cyc();
        end
        bus.M_AXI_ARREADY = 1'b0;
        chk("ar_valid_cycles", 64'(hi), 64'(delay + 1));
        #1;
        chk("ar_valid_drop", 64'(bus.M_AXI_ARVALID), 64'h0);
    endtask

    // AXI slave data phase: RLAST on beat index last_at, optional RREADY toggling by the owner.
    task automatic do_data(input logic w, input int last_at, input logic rid,
                           input logic toggle, input int exp_n);
        int beat;
        int got;
        int guard;
        logic rr;
        logic own;
        logic [63:0] d;
        beat  = 0;
        got   = 0;
        guard = 0;
        while (beat <= last_at && guard < 64) begin
            guard++;
            rr = toggle ? guard[0] : 1'b1;
            d  = {32'hA5A5_0000, 24'(w), 8'(beat)};
            bus.M_AXI_RVALID = 1'b1;
            bus.M_AXI_RDATA  = d;
            bus.M_AXI_RLAST  = (beat == last_at);
            bus.M_AXI_RID    = rid;
            bus.S0_RREADY    = w ? ~rr : rr;
            bus.S1_RREADY    = w ? rr : ~rr;
            #1;
            own = w ? bus.S1_RVALID : bus.S0_RVALID;
            chk("r_rready",      64'(bus.M_AXI_RREADY), 64'(rr));
            chk("r_valid_own",   64'(own), 64'h1);
            chk("r_valid_other", 64'(w ? bus.S0_RVALID : bus.S1_RVALID), 64'h0);
            chk("r_data",        bus.S_RDATA, d);
            if (own === 1'b1 && rr) got++;
            if (bus.M_AXI_RREADY === 1'b1) beat++;
            cyc();
        end
        bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RLAST  = 1'b0;
        bus.M_AXI_RID    = 1'b0;
        bus.S0_RREADY    = 1'b0;
        bus.S1_RREADY    = 1'b0;
        chk("r_beats", 64'(got), 64'(exp_n));
    endtask

    initial begin
        logic w;
        ntests = 0;
        nfail  = 0;
        ARESETN = 1'b0;
        bus.S0_ARADDR = '0; bus.S0_ARLEN = '0; bus.S0_ARVALID = 1'b0; bus.S0_RREADY = 1'b0;
        bus.S1_ARADDR = '0; bus.S1_ARLEN = '0; bus.S1_ARVALID = 1'b0; bus.S1_RREADY = 1'b0;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RID = 1'b0; bus.M_AXI_RLAST = 1'b0; bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RDATA = 64'hDEAD_BEEF_0123_4567;

        // Reset values
        cyc(); #1;
        chk("rst_arready", 64'({bus.S1_ARREADY, bus.S0_ARREADY}), 64'h0);
        chk("rst_rvalid",  64'({bus.S1_RVALID, bus.S0_RVALID}),   64'h0);
        chk("rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'h0);
        chk("rst_rready",  64'(bus.M_AXI_RREADY),  64'h0);
        chk("rst_arid",    64'(bus.M_AXI_ARID),    64'h0);
        chk("rst_araddr",  64'(bus.M_AXI_ARADDR),  64'h0);
        chk("rst_arlen",   64'(bus.M_AXI_ARLEN),   64'h0);
        chk("rst_err",     64'(bus.ARB_ERR),       64'h0);
        chk("rst_rdata",   bus.S_RDATA, 64'hDEAD_BEEF_0123_4567);
        cyc();
        ARESETN = 1'b1;

        // Both requesting from reset: S0 first, then alternate (S0 every time with fixed priority)
        bus.S0_ARADDR = 32'h0000_1000; bus.S0_ARLEN = 8'd1;
        bus.S1_ARADDR = 32'h0000_2000; bus.S1_ARLEN = 8'd1;
        for (int k = 0; k < 4; k++) begin
`ifdef VRAM_RD_ARB_S0_PRIO_EN
            w = 1'b0;
`else
            w = k[0];
`endif
            grant(1'b1, 1'b1, w, 1'b0);
            do_addr(w, w ? 32'h0000_2000 : 32'h0000_1000, 8'd1, 0);
            do_data(w, 1, w, 1'b0, 2);
        end
        bus.S0_ARVALID = 1'b0;
        bus.S1_ARVALID = 1'b0;
        chk("contest_err", 64'(bus.ARB_ERR), 64'h0);

        // S0 alone, 16-beat burst
        bus.S0_ARADDR = 32'h2000_0000; bus.S0_ARLEN = 8'd15;
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_0000, 8'd15, 0);
        do_data(1'b0, 15, 1'b0, 1'b0, 16);
        chk("s0_long_err", 64'(bus.ARB_ERR), 64'h0);

        // ARREADY delayed 5 cycles
        bus.S0_ARADDR = 32'h2000_0400; bus.S0_ARLEN = 8'd2;
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_0400, 8'd2, 5);
        do_data(1'b0, 2, 1'b0, 1'b0, 3);

        // S1 LEN 3 with its RREADY toggling
        bus.S1_ARADDR = 32'h3000_0040; bus.S1_ARLEN = 8'd3;
        grant(1'b0, 1'b1, 1'b1, 1'b1);
        do_addr(1'b1, 32'h3000_0040, 8'd3, 0);
        do_data(1'b1, 3, 1'b1, 1'b1, 4);
        chk("s1_toggle_err", 64'(bus.ARB_ERR), 64'h0);

        // Early RLAST on LEN 7, then wrong RID; flag must stick
        bus.S0_ARADDR = 32'h2000_0800; bus.S0_ARLEN = 8'd7;
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_0800, 8'd7, 0);
        do_data(1'b0, 2, 1'b0, 1'b0, 3);
        chk("early_last_err", 64'(bus.ARB_ERR), 64'h1);
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_0800, 8'd7, 0);
        do_data(1'b0, 7, 1'b1, 1'b0, 8);
        chk("err_sticky", 64'(bus.ARB_ERR), 64'h1);

        // Async reset during DATA beat 4
        bus.S0_ARADDR = 32'h2000_1000; bus.S0_ARLEN = 8'd7;
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_1000, 8'd7, 0);
        for (int i = 0; i < 4; i++) begin
            bus.M_AXI_RVALID = 1'b1;
            bus.M_AXI_RDATA  = 64'(i);
            bus.S0_RREADY    = 1'b1;
            cyc();
        end
        bus.M_AXI_RDATA = 64'h0000_0000_0000_0004;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_rvalid",  64'({bus.S1_RVALID, bus.S0_RVALID}), 64'h0);
        chk("mid_rst_rready",  64'(bus.M_AXI_RREADY),  64'h0);
        chk("mid_rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'h0);
        chk("mid_rst_araddr",  64'(bus.M_AXI_ARADDR),  64'h0);
        chk("mid_rst_arlen",   64'(bus.M_AXI_ARLEN),   64'h0);
        chk("mid_rst_err",     64'(bus.ARB_ERR),       64'h0);
        bus.M_AXI_RVALID = 1'b0;
        bus.S0_RREADY    = 1'b0;
        cyc();
        ARESETN = 1'b1;
        bus.S0_ARADDR = 32'h2000_2000; bus.S0_ARLEN = 8'd3;
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_2000, 8'd3, 0);
        do_data(1'b0, 3, 1'b0, 1'b0, 4);
        chk("post_rst_err", 64'(bus.ARB_ERR), 64'h0);

        // Wrong RID alone on an S1 burst
        bus.S1_ARADDR = 32'h3000_0100; bus.S1_ARLEN = 8'd1;
        grant(1'b0, 1'b1, 1'b1, 1'b1);
        do_addr(1'b1, 32'h3000_0100, 8'd1, 0);
        do_data(1'b1, 1, 1'b0, 1'b0, 2);
        chk("bad_rid_err", 64'(bus.ARB_ERR), 64'h1);

        // Burst runs past ARLEN without RLAST
        ARESETN = 1'b0;
        cyc();
        ARESETN = 1'b1;
        bus.S0_ARADDR = 32'h2000_3000; bus.S0_ARLEN = 8'd1;
        grant(1'b1, 1'b0, 1'b0, 1'b1);
        do_addr(1'b0, 32'h2000_3000, 8'd1, 0);
        do_data(1'b0, 2, 1'b0, 1'b0, 3);
        chk("no_last_err", 64'(bus.ARB_ERR), 64'h1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
